// File: rtl/l1d_line_axi_bridge_if.sv
// AXI-style memory bus bundle between the L1D line bridge and L2 / memory.
// master: bridge side (drives AR/AW/W, R/B ready). slave: memory side.
interface l1d_line_axi_bridge_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 12,
  parameter int AXI_DATA_WIDTH = 64
);
  // AR channel
  logic                        m_arvalid;
  logic                        m_arready;
  logic [ADDR_WIDTH-1:0]       m_araddr;
  logic [ID_WIDTH-1:0]         m_arid;
  // AW channel
  logic                        m_awvalid;
  logic                        m_awready;
  logic [ADDR_WIDTH-1:0]       m_awaddr;
  logic [ID_WIDTH-1:0]         m_awid;
  // W channel
  logic                        m_wvalid;
  logic                        m_wready;
  logic [AXI_DATA_WIDTH-1:0]   m_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_wstrb;
  logic                        m_wlast;
  // R channel
  logic                        m_rvalid;
  logic                        m_rready;
  logic [AXI_DATA_WIDTH-1:0]   m_rdata;
  logic [ID_WIDTH-1:0]         m_rid;
  logic [1:0]                  m_rresp;
  logic                        m_rlast;
  // B channel
  logic                        m_bvalid;
  logic                        m_bready;
  logic [ID_WIDTH-1:0]         m_bid;
  logic [1:0]                  m_bresp;

  modport master (
    output m_arvalid, m_araddr, m_arid,
    input  m_arready,
    output m_awvalid, m_awaddr, m_awid,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb, m_wlast,
    input  m_wready,
    input  m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
    output m_rready,
    input  m_bvalid, m_bid, m_bresp,
    output m_bready
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arid,
    output m_arready,
    input  m_awvalid, m_awaddr, m_awid,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast,
    output m_wready,
    output m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
    input  m_rready,
    output m_bvalid, m_bid, m_bresp,
    input  m_bready
  );
endinterface

// File: rtl/l1d_line_axi_bridge.sv
// L1D line <-> AXI bridge.
// Read path: one AR per line refill, R beats reassembled into a full line.
// Write path: one AW plus BEATS W beats per eviction, B returned to the EWRQ.
// Optional macro L1D_LINE_AXI_BRIDGE_CHECK_EN builds a sticky protocol checker
// driving proto_err; without it proto_err is tied low.
module l1d_line_axi_bridge #(
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  // line refill request / response
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  input  logic [ID_WIDTH-1:0]     rd_req_id,
  output logic                    rd_resp_valid,
  input  logic                    rd_resp_ready,
  output logic [ID_WIDTH-1:0]     rd_resp_id,
  output logic [LINE_WIDTH-1:0]   rd_resp_data,
  output logic                    rd_resp_err,
  // eviction request / response
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [ID_WIDTH-1:0]     wr_req_id,
  input  logic [LINE_WIDTH-1:0]   wr_req_data,
  input  logic [LINE_WIDTH/8-1:0] wr_req_mask,
  output logic                    wr_resp_valid,
  input  logic                    wr_resp_ready,
  output logic [ID_WIDTH-1:0]     wr_resp_id,
  output logic                    wr_resp_err,
  // memory bus
  l1d_line_axi_bridge_if.master   m_axi,
  output logic                    proto_err
);

  localparam int BEATS  = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS   = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

  // ---------------------------------------------------------------------------
  // AR: single-entry output register, refilled in the same cycle it drains
  // ---------------------------------------------------------------------------
  logic                  ar_valid_reg;
  logic [ADDR_WIDTH-1:0] ar_addr_reg;
  logic [ID_WIDTH-1:0]   ar_id_reg;

  assign rd_req_ready    = !ar_valid_reg || m_axi.m_arready;
  assign m_axi.m_arvalid = ar_valid_reg;
  assign m_axi.m_araddr  = ar_addr_reg;
  assign m_axi.m_arid    = ar_id_reg;

  // Load a new line address on accept, otherwise drop valid once AR is taken
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ar_valid_reg <= 1'b0;
      ar_addr_reg  <= '0;
      ar_id_reg    <= '0;
    end else if (rd_req_valid && rd_req_ready) begin
      ar_valid_reg <= 1'b1;
      ar_addr_reg  <= rd_req_addr & ALIGN_MASK;
      ar_id_reg    <= rd_req_id;
    end else if (m_axi.m_arready) begin
      ar_valid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // R: beat counter and line reassembly buffer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]          r_cnt_reg;
  logic                      rd_valid_reg;
  logic [ID_WIDTH-1:0]       rd_id_reg;
  logic                      rd_err_reg;
  logic [AXI_DATA_WIDTH-1:0] r_beat_reg [BEATS];
  logic                      r_hs;
  logic                      r_last_beat;

  // The buffer only accepts beats while no assembled line is waiting, so a
  // pending line can never be overwritten.
  assign m_axi.m_rready = !rd_valid_reg;
  assign r_hs           = m_axi.m_rvalid && m_axi.m_rready;
  assign r_last_beat    = (r_cnt_reg == LAST_BEAT);

  assign rd_resp_valid = rd_valid_reg;
  assign rd_resp_id    = rd_id_reg;
  assign rd_resp_err   = rd_err_reg;

  // Count beats, accumulate the error over the burst, publish on the last beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt_reg    <= '0;
      rd_valid_reg <= 1'b0;
      rd_id_reg    <= '0;
      rd_err_reg   <= 1'b0;
    end else begin
      if (r_hs) begin
        if (r_cnt_reg == '0)
          rd_err_reg <= (m_axi.m_rresp != 2'b00);
        else
          rd_err_reg <= rd_err_reg || (m_axi.m_rresp != 2'b00);
        if (r_last_beat) begin
          r_cnt_reg    <= '0;
          rd_valid_reg <= 1'b1;
          rd_id_reg    <= m_axi.m_rid;
        end else begin
          r_cnt_reg <= r_cnt_reg + 1'b1;
        end
      end else if (rd_resp_ready) begin
        rd_valid_reg <= 1'b0;
      end
    end
  end

  // Store each accepted beat into its slot of the line buffer
  always_ff @(posedge clk) begin
    if (r_hs)
      r_beat_reg[r_cnt_reg] <= m_axi.m_rdata;
  end

  // Beat 0 lands in the least-significant slice of the line
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_rd_line
    assign rd_resp_data[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_beat_reg[gi];
  end

  // ---------------------------------------------------------------------------
  // Write FSM: one outstanding eviction at a time
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  w_state_t                  w_state_reg;
  logic                      aw_valid_reg;
  logic                      w_valid_reg;
  logic [CNT_W-1:0]          w_cnt_reg;
  logic [ADDR_WIDTH-1:0]     wr_addr_reg;
  logic [ID_WIDTH-1:0]       wr_id_reg;
  logic [LINE_WIDTH-1:0]     wr_data_reg;
  logic [LINE_WIDTH/8-1:0]   wr_mask_reg;
  logic                      wr_resp_valid_reg;
  logic [ID_WIDTH-1:0]       wr_resp_id_reg;
  logic                      wr_resp_err_reg;
  logic [AXI_DATA_WIDTH-1:0] w_beat [BEATS];
  logic [STRB_W-1:0]         w_strb [BEATS];
  logic                      aw_hs;
  logic                      w_hs;
  logic                      w_last;
  logic                      b_hs;
  logic                      wr_accept;

  // Slice the latched line and mask into per-beat views
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wr_line
    assign w_beat[gi] = wr_data_reg[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_strb[gi] = wr_mask_reg[gi*STRB_W +: STRB_W];
  end

  assign wr_req_ready    = (w_state_reg == W_IDLE);
  assign wr_accept       = wr_req_valid && wr_req_ready;
  assign m_axi.m_awvalid = aw_valid_reg;
  assign m_axi.m_awaddr  = wr_addr_reg;
  assign m_axi.m_awid    = wr_id_reg;
  assign m_axi.m_wvalid  = w_valid_reg;
  assign m_axi.m_wdata   = w_beat[w_cnt_reg];
  assign m_axi.m_wstrb   = w_strb[w_cnt_reg];
  assign m_axi.m_wlast   = w_last;
  // B is held off while the previous response still waits for the EWRQ
  assign m_axi.m_bready  = (w_state_reg == W_RESP) && !wr_resp_valid_reg;

  assign w_last = (w_cnt_reg == LAST_BEAT);
  assign aw_hs  = aw_valid_reg && m_axi.m_awready;
  assign w_hs   = w_valid_reg && m_axi.m_wready;
  assign b_hs   = m_axi.m_bvalid && m_axi.m_bready;

  assign wr_resp_valid = wr_resp_valid_reg;
  assign wr_resp_id    = wr_resp_id_reg;
  assign wr_resp_err   = wr_resp_err_reg;

  // Write sequencing: accept line, push AW and W independently, await B
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_reg       <= W_IDLE;
      aw_valid_reg      <= 1'b0;
      w_valid_reg       <= 1'b0;
      w_cnt_reg         <= '0;
      wr_addr_reg       <= '0;
      wr_id_reg         <= '0;
      wr_resp_valid_reg <= 1'b0;
      wr_resp_id_reg    <= '0;
      wr_resp_err_reg   <= 1'b0;
    end else begin
      if (wr_resp_ready)
        wr_resp_valid_reg <= 1'b0;
      case (w_state_reg)
        W_IDLE: begin
          if (wr_req_valid) begin
            wr_addr_reg  <= wr_req_addr & ALIGN_MASK;
            wr_id_reg    <= wr_req_id;
            aw_valid_reg <= 1'b1;
            w_valid_reg  <= 1'b1;
            w_cnt_reg    <= '0;
            w_state_reg  <= W_SEND;
          end
        end
        W_SEND: begin
          if (aw_hs)
            aw_valid_reg <= 1'b0;
          if (w_hs) begin
            if (w_last)
              w_valid_reg <= 1'b0;
            else
              w_cnt_reg <= w_cnt_reg + 1'b1;
          end
          // Done once AW is (being) taken and the final W is (being) taken
          if ((!aw_valid_reg || m_axi.m_awready) &&
              (!w_valid_reg || (m_axi.m_wready && w_last)))
            w_state_reg <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            wr_resp_valid_reg <= 1'b1;
            wr_resp_id_reg    <= m_axi.m_bid;
            wr_resp_err_reg   <= (m_axi.m_bresp != 2'b00);
            w_state_reg       <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Capture line payload on accept; no reset needed since valids gate its use
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wr_data_reg <= wr_req_data;
      wr_mask_reg <= wr_req_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------
`ifdef L1D_LINE_AXI_BRIDGE_CHECK_EN
  logic                proto_err_reg;
  logic [ID_WIDTH-1:0] r_first_id_reg;

  assign proto_err = proto_err_reg;

  // Sticky flag on rlast misplacement, rid change, stray B, or wrong bid
  always_ff @(posedge clk) begin
    if (!rstn) begin
      proto_err_reg  <= 1'b0;
      r_first_id_reg <= '0;
    end else begin
      if (r_hs && (r_cnt_reg == '0))
        r_first_id_reg <= m_axi.m_rid;
      if (r_hs && (m_axi.m_rlast != r_last_beat)) begin
        proto_err_reg <= 1'b1;
`ifndef SYNTHESIS
        $error("l1d_line_axi_bridge: rlast mismatch at beat %0d", r_cnt_reg);
`endif
      end
      if (r_hs && (r_cnt_reg != '0) && (m_axi.m_rid != r_first_id_reg)) begin
        proto_err_reg <= 1'b1;
`ifndef SYNTHESIS
        $error("l1d_line_axi_bridge: rid changed mid-burst");
`endif
      end
      if (m_axi.m_bvalid && (w_state_reg != W_RESP)) begin
        proto_err_reg <= 1'b1;
`ifndef SYNTHESIS
        $error("l1d_line_axi_bridge: bvalid with no write awaiting response");
`endif
      end
      if (b_hs && (m_axi.m_bid != wr_id_reg)) begin
        proto_err_reg <= 1'b1;
`ifndef SYNTHESIS
        $error("l1d_line_axi_bridge: bid does not match issued awid");
`endif
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule
